// File: rtl/cache_miss_ctrl.sv
// Per-set miss controller: serves hits combinationally and, on a miss, writes back
// the LRU way (if dirty) and refills it from memory word by word.
module cache_miss_ctrl #(
  parameter int TAG_WIDTH  = 24,
  parameter int SET_WIDTH  = 4,
  parameter int LINE_WIDTH = 4,
  parameter int WAYS       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_ready,
  output logic [31:0]               cpu_rdata,
  input  logic [WAYS-1:0]           way_hit,
  input  logic [WAYS-1:0]           way_dirty,
  input  logic [WAYS*TAG_WIDTH-1:0] way_tag,
  input  logic [WAYS*32-1:0]        way_tick,
  input  logic [WAYS*32-1:0]        way_out,
  output logic [WAYS-1:0]           line_en,
  output logic [TAG_WIDTH-1:0]      line_target,
  output logic [LINE_WIDTH-1:0]     line_index,
  output logic                      line_write_en,
  output logic                      line_set_dirty,
  output logic [TAG_WIDTH-1:0]      line_set_tag,
  output logic [31:0]               line_data,
  output logic                      line_tick_en,
  output logic [31:0]               line_set_tick,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack
);

  localparam int KW = LINE_WIDTH - 2;
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [KW-1:0]          k_r, k_nx_s;
  logic [VW-1:0]          victim_r, victim_nx_s;
  logic [TAG_WIDTH-1:0]   victim_tag_r, victim_tag_nx_s;
  logic [31:0]            tick_r, tick_nx_s;

  logic [TAG_WIDTH-1:0]   cpu_tag_s;
  logic [SET_WIDTH-1:0]   cpu_set_s;
  logic [WAYS-1:0]        hit_onehot_s;
  logic [WAYS-1:0]        victim_onehot_s;
  logic [31:0]            rdata_or_s;
  logic [31:0]            victim_out_s;
  logic [VW-1:0]          lru_way_s;
  logic [31:0]            lru_tick_s;
  logic                   last_word_s;
  logic                   unused_addr_s;

  assign cpu_tag_s       = cpu_addr[31 -: TAG_WIDTH];
  assign cpu_set_s       = cpu_addr[LINE_WIDTH +: SET_WIDTH];
  assign victim_onehot_s = WAYS'(1'b1) << victim_r;
  assign victim_out_s    = way_out[victim_r*32 +: 32];
  assign last_word_s     = (k_r == {KW{1'b1}});
  assign unused_addr_s   = ^cpu_addr[1:0];

  // Per-way reductions: lowest hitting way, OR of word outputs, LRU pick (ties to lowest index)
  always_comb begin
    hit_onehot_s = {WAYS{1'b0}};
    rdata_or_s   = 32'h0000_0000;
    lru_way_s    = {VW{1'b0}};
    lru_tick_s   = way_tick[31:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_onehot_s = way_hit[w] ? (WAYS'(1'b1) << w) : hit_onehot_s;
    end
    for (int w = 0; w < WAYS; w++) begin
      rdata_or_s = rdata_or_s | way_out[w*32 +: 32];
    end
    for (int w = 1; w < WAYS; w++) begin
      lru_way_s  = (way_tick[w*32 +: 32] < lru_tick_s) ? VW'(w) : lru_way_s;
      lru_tick_s = (way_tick[w*32 +: 32] < lru_tick_s) ? way_tick[w*32 +: 32] : lru_tick_s;
    end
  end

  // Line addressing and memory request; kept independent of the way_* inputs
  always_comb begin
    line_target = cpu_tag_s;
    line_index  = {cpu_addr[LINE_WIDTH-1:2], 2'b00};
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0000_0000;
    if (reset) begin
      mem_req = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_req = 1'b0;
        end
        WRITEBACK: begin
          line_target = victim_tag_r;
          line_index  = {k_r, 2'b00};
          mem_req     = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = {victim_tag_r, cpu_set_s, k_r, 2'b00};
        end
        REFILL: begin
          // the first refill write retags the line, so later words look it up by the new tag
          line_target = (k_r == {KW{1'b0}}) ? victim_tag_r : cpu_tag_s;
          line_index  = {k_r, 2'b00};
          mem_req     = 1'b1;
          mem_addr    = {cpu_tag_s, cpu_set_s, k_r, 2'b00};
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic, line strobes and CPU response
  always_comb begin
    state_nx_s      = state_r;
    k_nx_s          = k_r;
    victim_nx_s     = victim_r;
    victim_tag_nx_s = victim_tag_r;
    tick_nx_s       = tick_r;
    cpu_ready       = 1'b0;
    cpu_rdata       = 32'h0000_0000;
    line_en         = {WAYS{1'b0}};
    line_write_en   = 1'b0;
    line_set_dirty  = 1'b0;
    line_set_tag    = {TAG_WIDTH{1'b0}};
    line_data       = 32'h0000_0000;
    line_tick_en    = 1'b0;
    line_set_tick   = 32'h0000_0000;
    mem_wdata       = 32'h0000_0000;
    if (reset) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_req && (|way_hit)) begin
            cpu_ready     = 1'b1;
            line_en       = hit_onehot_s;
            line_tick_en  = 1'b1;
            line_set_tick = tick_r;
            tick_nx_s     = tick_r + 32'd1;
            if (cpu_we) begin
              line_write_en  = 1'b1;
              line_set_dirty = 1'b1;
              line_set_tag   = cpu_tag_s;
              line_data      = cpu_wdata;
            end else begin
              cpu_rdata = rdata_or_s;
            end
          end else if (cpu_req) begin
            victim_nx_s     = lru_way_s;
            victim_tag_nx_s = way_tag[lru_way_s*TAG_WIDTH +: TAG_WIDTH];
            k_nx_s          = {KW{1'b0}};
            state_nx_s      = way_dirty[lru_way_s] ? WRITEBACK : REFILL;
          end else begin
            state_nx_s = IDLE;
          end
        end
        WRITEBACK: begin
          line_en   = victim_onehot_s;
          mem_wdata = victim_out_s;
          if (mem_ack && last_word_s) begin
            k_nx_s     = {KW{1'b0}};
            state_nx_s = REFILL;
          end else if (mem_ack) begin
            k_nx_s = k_r + KW'(1'b1);
          end else begin
            k_nx_s = k_r;
          end
        end
        REFILL: begin
          line_en = victim_onehot_s;
          if (mem_ack) begin
            line_write_en  = 1'b1;
            line_set_dirty = 1'b0;
            line_set_tag   = cpu_tag_s;
            line_data      = mem_rdata;
            k_nx_s         = last_word_s ? {KW{1'b0}} : (k_r + KW'(1'b1));
            state_nx_s     = last_word_s ? IDLE : REFILL;
          end else begin
            k_nx_s = k_r;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      k_r          <= {KW{1'b0}};
      victim_r     <= {VW{1'b0}};
      victim_tag_r <= {TAG_WIDTH{1'b0}};
      tick_r       <= 32'h0000_0000;
    end else begin
      state_r      <= state_nx_s;
      k_r          <= k_nx_s;
      victim_r     <= victim_nx_s;
      victim_tag_r <= victim_tag_nx_s;
      tick_r       <= tick_nx_s;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hit vectors from a table, then miss, writeback,
// tie and reset sequences against a small line-array model and a memory responder.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  way_hit, way_dirty, line_en;
  logic [47:0] way_tag;
  logic [63:0] way_tick, way_out;
  logic [23:0] line_target, line_set_tag;
  logic [3:0]  line_index;
  logic        line_write_en, line_set_dirty, line_tick_en;
  logic [31:0] line_data, line_set_tick;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  cache_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .way_hit(way_hit), .way_dirty(way_dirty), .way_tag(way_tag), .way_tick(way_tick),
    .way_out(way_out),
    .line_en(line_en), .line_target(line_target), .line_index(line_index),
    .line_write_en(line_write_en), .line_set_dirty(line_set_dirty),
    .line_set_tag(line_set_tag), .line_data(line_data),
    .line_tick_en(line_tick_en), .line_set_tick(line_set_tick),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line-array model (2 ways x 4 words) and table override
  logic [23:0] m_tag[2], pl_tag[2];
  logic        m_dirty[2], pl_dirty[2];
  logic [31:0] m_tick[2], pl_tick[2];
  logic [31:0] m_data[2][4];
  logic        pl_en = 1'b0;
  logic        use_tbl;
  logic [1:0]  t_hit;
  logic [63:0] t_out;

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (pl_en) begin
        m_tag[w]   <= pl_tag[w];
        m_dirty[w] <= pl_dirty[w];
        m_tick[w]  <= pl_tick[w];
        for (int i = 0; i < 4; i++) m_data[w][i] <= 32'hD000_0000 + 32'(w * 16 + i);
      end else begin
        if (line_en[w] && line_write_en) begin
          m_tag[w]   <= line_set_tag;
          m_dirty[w] <= line_set_dirty;
          m_data[w][line_index[3:2]] <= line_data;
        end
        if (line_en[w] && line_tick_en) m_tick[w] <= line_set_tick;
      end
    end
  end

  always_comb begin
    way_hit = 2'b00; way_dirty = 2'b00; way_tag = 48'h0; way_tick = 64'h0; way_out = 64'h0;
    if (use_tbl) begin
      way_hit = t_hit;
      way_out = t_out;
    end else begin
      for (int w = 0; w < 2; w++) begin
        way_hit[w]            = (m_tag[w] == line_target);
        way_dirty[w]          = m_dirty[w];
        way_tag[w*24 +: 24]   = m_tag[w];
        way_tick[w*32 +: 32]  = m_tick[w];
        way_out[w*32 +: 32]   = way_hit[w] ? m_data[w][line_index[3:2]] : 32'h0;
      end
    end
  end

  // Memory responder: acks after mem_delay wait cycles, checks request stability while waiting
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;
  assign mem_rdata = mem_ack ? (mem_addr ^ 32'h5A5A_0000) : 32'h0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == 0) begin
        h_addr = mem_addr; h_wdata = mem_wdata; h_we = mem_we;
      end else begin
        chk("mem_hold_addr", mem_addr, h_addr);
        chk("mem_hold_we", {31'h0, mem_we}, {31'h0, h_we});
        if (h_we) chk("mem_hold_wdata", mem_wdata, h_wdata);
      end
      if (wait_cnt >= mem_delay) begin mem_ack = 1'b1; wait_cnt = 0; end
      else begin mem_ack = 1'b0; wait_cnt++; end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  end

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] data; logic [23:0] tgt; logic [1:0] en; logic wr;
  } rec_t;
  rec_t recs[$];

  typedef struct {
    logic req; logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] hit; logic [63:0] out;
    logic e_ready; logic [31:0] e_rdata; logic e_wr; logic [1:0] e_en; logic [3:0] e_idx;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] exp_tick = 32'd0;
  int cyc;

  task automatic preload(input logic [23:0] t0, input logic [23:0] t1, input logic d0,
                         input logic d1, input logic [31:0] k0, input logic [31:0] k1);
    pl_tag[0] = t0; pl_tag[1] = t1; pl_dirty[0] = d0; pl_dirty[1] = d1;
    pl_tick[0] = k0; pl_tick[1] = k1;
    @(negedge clk); pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic run_miss(input int budget, output int c_out);
    c_out = -1;
    recs.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (line_write_en || line_tick_en) chk("strobe_needs_en", {31'h0, line_en != 2'b00}, 32'd1);
      if (mem_req && mem_ack)
        recs.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata, line_target, line_en,
                         line_write_en});
      if (cpu_ready) begin c_out = c; break; end
    end
    if (c_out < 0) chk("miss_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_req();
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    use_tbl = 1'b1; t_hit = 2'b00; t_out = 64'h0;

    // outputs stay zero while reset is held, even with a hitting request
    @(negedge clk);
    apply(1'b0, 32'h000A_BC28, 32'h0); t_hit = 2'b10; t_out = {32'h1234_5678, 32'h0};
    #1;
    chk("rst_ready", {31'h0, cpu_ready}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_tick_en", {31'h0, line_tick_en}, 32'd0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h000A_BC28, 32'h0, 2'b10, {32'h1234_5678, 32'h0},
                1'b0, 32'h0, 1'b0, 2'b00, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h000A_BC28, 32'h0, 2'b10, {32'h1234_5678, 32'h0},
                1'b1, 32'h1234_5678, 1'b0, 2'b10, 4'h8};
    vecs[2] = '{1'b1, 1'b1, 32'h000A_BC28, 32'hDEAD_BEEF, 2'b10, {32'h1234_5678, 32'h0},
                1'b1, 32'h0, 1'b1, 2'b10, 4'h8};
    vecs[3] = '{1'b1, 1'b0, 32'h1234_5670, 32'h0, 2'b01, {32'h0, 32'hCAFE_F00D},
                1'b1, 32'hCAFE_F00D, 1'b0, 2'b01, 4'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h1234_5670, 32'h1, 2'b01, {32'h0, 32'hCAFE_F00D},
                1'b0, 32'h0, 1'b0, 2'b00, 4'h0};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1, 2'b01, {32'h0, 32'h0},
                1'b1, 32'h0, 1'b1, 2'b01, 4'hC};
    vecs[6] = '{1'b1, 1'b0, 32'h000A_BC2B, 32'h0, 2'b10, {32'h55AA_55AA, 32'h0},
                1'b1, 32'h55AA_55AA, 1'b0, 2'b10, 4'h8};

    foreach (vecs[i]) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      cpu_wdata = vecs[i].wdata; t_hit = vecs[i].hit; t_out = vecs[i].out;
      @(negedge clk); #1;
      chk($sformatf("v%0d_ready", i), {31'h0, cpu_ready}, {31'h0, vecs[i].e_ready});
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_write_en", i), {31'h0, line_write_en}, {31'h0, vecs[i].e_wr});
      chk($sformatf("v%0d_tick_en", i), {31'h0, line_tick_en}, {31'h0, vecs[i].e_ready});
      chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, 32'd0);
      if (vecs[i].e_ready) begin
        chk($sformatf("v%0d_line_en", i), {30'h0, line_en}, {30'h0, vecs[i].e_en});
        chk($sformatf("v%0d_index", i), {28'h0, line_index}, {28'h0, vecs[i].e_idx});
        chk($sformatf("v%0d_set_tick", i), line_set_tick, exp_tick);
        exp_tick = exp_tick + 32'd1;
      end
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_data", i), line_data, vecs[i].wdata);
        chk($sformatf("v%0d_set_dirty", i), {31'h0, line_set_dirty}, 32'd1);
        chk($sformatf("v%0d_set_tag", i), {8'h0, line_set_tag}, {8'h0, vecs[i].addr[31:8]});
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0; use_tbl = 1'b0;

    // clean miss: ticks {5,3} -> way 1 refilled
    preload(24'h111111, 24'h222222, 1'b0, 1'b0, 32'd5, 32'd3);
    mem_delay = 0;
    apply(1'b0, 32'h3333_3354, 32'h0);
    run_miss(20, cyc);
    chk("clean_latency", cyc, 32'd5);
    chk("clean_words", recs.size(), 32'd4);
    for (int i = 0; i < 4 && i < recs.size(); i++) begin
      chk($sformatf("clean_addr%0d", i), recs[i].addr, 32'h3333_3350 + 32'(4 * i));
      chk($sformatf("clean_we%0d", i), {31'h0, recs[i].we}, 32'd0);
      chk($sformatf("clean_en%0d", i), {30'h0, recs[i].en}, 32'd2);
      chk($sformatf("clean_wr%0d", i), {31'h0, recs[i].wr}, 32'd1);
      chk($sformatf("clean_tgt%0d", i), {8'h0, recs[i].tgt}, (i == 0) ? 32'h222222 : 32'h333333);
    end
    chk("clean_rdata", cpu_rdata, 32'h6969_3354);
    chk("clean_tick", line_set_tick, exp_tick);
    exp_tick = exp_tick + 32'd1;
    finish_req();
    chk("clean_way1_tag", {8'h0, m_tag[1]}, 32'h333333);
    chk("clean_way0_tag", {8'h0, m_tag[0]}, 32'h111111);

    // dirty miss with 3 wait cycles per word
    preload(24'h444444, 24'h555555, 1'b1, 1'b0, 32'd2, 32'd9);
    mem_delay = 3;
    apply(1'b0, 32'h6666_663C, 32'h0);
    run_miss(60, cyc);
    chk("dirty_latency", cyc, 32'd33);
    chk("dirty_words", recs.size(), 32'd8);
    for (int i = 0; i < 8 && i < recs.size(); i++) begin
      chk($sformatf("dirty_we%0d", i), {31'h0, recs[i].we}, (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("dirty_en%0d", i), {30'h0, recs[i].en}, 32'd1);
      if (i < 4) begin
        chk($sformatf("dirty_waddr%0d", i), recs[i].addr, 32'h4444_4430 + 32'(4 * i));
        chk($sformatf("dirty_wdata%0d", i), recs[i].data, 32'hD000_0000 + 32'(i));
      end else begin
        chk($sformatf("dirty_raddr%0d", i), recs[i].addr, 32'h6666_6630 + 32'(4 * (i - 4)));
      end
    end
    chk("dirty_rdata", cpu_rdata, 32'h3C3C_663C);
    chk("dirty_tick", line_set_tick, exp_tick);
    exp_tick = exp_tick + 32'd1;
    finish_req();
    chk("dirty_cleared", {31'h0, m_dirty[0]}, 32'd0);
    chk("dirty_retag", {8'h0, m_tag[0]}, 32'h666666);

    // tie on ticks -> lowest way
    preload(24'h777777, 24'h888888, 1'b0, 1'b0, 32'd7, 32'd7);
    mem_delay = 0;
    apply(1'b0, 32'h9999_9910, 32'h0);
    run_miss(20, cyc);
    chk("tie_latency", cyc, 32'd5);
    if (recs.size() > 0) chk("tie_victim_en", {30'h0, recs[0].en}, 32'd1);
    else chk("tie_no_words", 32'd0, 32'd1);
    exp_tick = exp_tick + 32'd1;
    finish_req();
    chk("tie_way0_tag", {8'h0, m_tag[0]}, 32'h999999);
    chk("tie_way1_tag", {8'h0, m_tag[1]}, 32'h888888);

    // reset on the second refill word
    preload(24'hBBBBBB, 24'hCCCCCC, 1'b0, 1'b0, 32'd1, 32'd4);
    apply(1'b0, 32'hAAAA_AA10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rstmid_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rstmid_write_en", {31'h0, line_write_en}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rstnext_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rstnext_ready", {31'h0, cpu_ready}, 32'd0);
    @(posedge clk); #1;
    apply(1'b0, 32'hAAAA_AA10, 32'h0);
    @(negedge clk); #1;
    chk("rstnext_hit", {31'h0, cpu_ready}, 32'd1);
    chk("rstnext_tick", line_set_tick, 32'd0);
    chk("rstnext_word0", cpu_rdata, 32'hF0F0_AA10);
    @(posedge clk); #1;
    apply(1'b0, 32'hAAAA_AA14, 32'h0);
    @(negedge clk); #1;
    chk("rstnext_word1_kept", cpu_rdata, 32'hD000_0001);
    chk("rstnext_tick1", line_set_tick, 32'd1);
    finish_req();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
